// File: rtl/emib_host_if.sv
// emib_host_if: bridges the asynchronous host bus (CS/WE/OE strobes, address, 16-bit data)
// into single-cycle EMIB RAM read/write requests in the i_clk domain, returning read data
// to the host after a fixed RD_LAT capture latency.
// Optional feature: define EMIB_WR_PROTECT_EN to drop writes at or above PROT_BASE and
// count them on o_wr_reject_cnt.

`ifndef ADDR_SZ
`define ADDR_SZ 12
`endif

module emib_host_if #(
  parameter int unsigned RD_LAT      = 3,
  parameter int unsigned TIMEOUT_CYC = 1024
`ifdef EMIB_WR_PROTECT_EN
  ,
  parameter logic [`ADDR_SZ-1:0] PROT_BASE = '0
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ext_cs_n,
  input  logic                i_ext_we_n,
  input  logic                i_ext_oe_n,
  input  logic [`ADDR_SZ-1:0] i_ext_addr,
  input  logic [15:0]         i_ext_wdata,
  output logic [15:0]         o_ext_rdata,
  output logic                o_ext_rdata_oe,
  output logic                o_wr_en_out,
  output logic [`ADDR_SZ-1:0] o_emib_wr_address,
  output logic [15:0]         o_emib_wr_data,
  output logic                o_rd_en_out,
  output logic [`ADDR_SZ-1:0] o_emib_rd_address,
  input  logic [15:0]         i_emib_rd_data,
  output logic                o_busy,
`ifdef EMIB_WR_PROTECT_EN
  output logic [15:0]         o_wr_reject_cnt,
`endif
  output logic                o_timeout
);

  localparam int unsigned RdCntW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [RdCntW-1:0] RdLatCnt = RdCntW'(RD_LAT);
  localparam logic [10:0] TmoLast = 11'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StRdReq,
    StRdWait,
    StRdHold,
    StWaitEnd
  } state_t;

  state_t state, next_state;

  logic cs_s1, cs_n_s, we_s1, we_n_s, oe_s1, oe_n_s;
  logic [1:0] sync_ok;
  logic armed;
  logic [RdCntW-1:0] rd_cnt;
  logic [10:0] tmo_cnt;
  logic [`ADDR_SZ-1:0] wr_addr, rd_addr;
  logic [15:0] wr_data, rdata;
  logic timeout_pulse;
  logic start_wr, start_rd, tmo_hit, capture, wr_drop;

  // Two-flop strobe synchronizers; idle-high so reset looks like a released bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cs_s1  <= 1'b1;
      cs_n_s <= 1'b1;
      we_s1  <= 1'b1;
      we_n_s <= 1'b1;
      oe_s1  <= 1'b1;
      oe_n_s <= 1'b1;
    end else begin
      cs_s1  <= i_ext_cs_n;
      cs_n_s <= cs_s1;
      we_s1  <= i_ext_we_n;
      we_n_s <= we_s1;
      oe_s1  <= i_ext_oe_n;
      oe_n_s <= oe_s1;
    end
  end

  // Marks when the synchronizer outputs reflect real pin samples rather than reset values,
  // so a strobe held low across reset release cannot arm the interface.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_ok <= 2'b00;
    end else begin
      sync_ok <= {sync_ok[0], 1'b1};
    end
  end

  // Decode access starts, timeout expiry, read-data capture and protected-write drop.
  always_comb begin
    start_wr = (state == StIdle) & armed & ~cs_n_s & ~we_n_s;
    start_rd = (state == StIdle) & armed & ~cs_n_s & we_n_s & ~oe_n_s;
    tmo_hit  = (state != StIdle) & (tmo_cnt == TmoLast);
    capture  = (state == StRdWait) & (rd_cnt == RdLatCnt);
`ifdef EMIB_WR_PROTECT_EN
    wr_drop  = (wr_addr >= PROT_BASE);
`else
    wr_drop  = 1'b0;
`endif
  end

  // Arm flag: set once the host has released the strobes, cleared when an access starts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      armed <= 1'b0;
    end else if (start_wr | start_rd) begin
      armed <= 1'b0;
    end else if (sync_ok[1] & (cs_n_s | (we_n_s & oe_n_s))) begin
      armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= StIdle;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; timeout overrides every other transition.
  always_comb begin
    next_state = state;
    unique case (state)
      StIdle: begin
        if (start_wr) begin
          next_state = StWrReq;
        end else if (start_rd) begin
          next_state = StRdReq;
        end
      end
      StWrReq:   next_state = StWaitEnd;
      StRdReq:   next_state = StRdWait;
      StRdWait:  if (capture) next_state = StRdHold;
      StRdHold:  if (oe_n_s | cs_n_s) next_state = StIdle;
      StWaitEnd: if (cs_n_s | we_n_s) next_state = StIdle;
      default:   next_state = StIdle;
    endcase
    if (tmo_hit) begin
      next_state = StIdle;
    end
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    o_wr_en_out    = (state == StWrReq) & ~wr_drop;
    o_rd_en_out    = (state == StRdReq);
    o_ext_rdata_oe = (state == StRdHold);
    o_busy         = (state != StIdle);
  end

  // Latch host address/data at access start; held until the next access of that kind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_addr <= '0;
      wr_data <= '0;
      rd_addr <= '0;
    end else if (start_wr) begin
      wr_addr <= i_ext_addr;
      wr_data <= i_ext_wdata;
    end else if (start_rd) begin
      rd_addr <= i_ext_addr;
    end
  end

  // Read latency counter: 1 in the first wait cycle, capture when it reaches RD_LAT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_cnt <= '0;
    end else if (state == StRdReq) begin
      rd_cnt <= RdCntW'(1);
    end else if (state == StRdWait) begin
      rd_cnt <= rd_cnt + RdCntW'(1);
    end
  end

  // Access timeout counter: cleared at start, counts every non-idle cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= '0;
    end else if (start_wr | start_rd) begin
      tmo_cnt <= '0;
    end else if (state != StIdle) begin
      tmo_cnt <= tmo_cnt + 11'd1;
    end
  end

  // Read data capture and one-cycle timeout pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= tmo_hit;
      if (capture) begin
        rdata <= i_emib_rd_data;
      end
    end
  end

`ifdef EMIB_WR_PROTECT_EN
  logic [15:0] reject_cnt;

  // Saturating count of writes dropped by the protection window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      reject_cnt <= '0;
    end else if ((state == StWrReq) && wr_drop && (reject_cnt != 16'hFFFF)) begin
      reject_cnt <= reject_cnt + 16'd1;
    end
  end

  assign o_wr_reject_cnt = reject_cnt;
`endif

  assign o_ext_rdata       = rdata;
  assign o_emib_wr_address = wr_addr;
  assign o_emib_wr_data    = wr_data;
  assign o_emib_rd_address = rd_addr;
  assign o_timeout         = timeout_pulse;

endmodule

// File: tb/tb_emib_host_if.sv
// Directed testbench for emib_host_if: host write, read with fixed-latency capture,
// simultaneous strobes, access timeout, reset during a read, and (with
// EMIB_WR_PROTECT_EN) write protection.

`ifndef ADDR_SZ
`define ADDR_SZ 12
`endif

module tb_emib_host_if;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cs_n = 1'b1;
  logic                we_n = 1'b1;
  logic                oe_n = 1'b1;
  logic [`ADDR_SZ-1:0] ext_addr = '0;
  logic [15:0]         ext_wdata = '0;
  logic [15:0]         ext_rdata;
  logic                ext_rdata_oe;
  logic                wr_en;
  logic [`ADDR_SZ-1:0] wr_address;
  logic [15:0]         wr_data;
  logic                rd_en;
  logic [`ADDR_SZ-1:0] rd_address;
  logic [15:0]         emib_rd_data;
  logic                busy;
  logic                timeout;
`ifdef EMIB_WR_PROTECT_EN
  logic [15:0]         reject_cnt;
`endif

  int n_asserts = 0;
  int n_fail = 0;

  // Monitor counters (written only by the monitor process).
  int wr_pulses = 0;
  int rd_pulses = 0;
  int tmo_pulses = 0;
  logic [`ADDR_SZ-1:0] last_wr_addr = '0;

  // Read-data model: valid exactly three cycles after the read request.
  logic [2:0]  rd_pipe = 3'b000;
  logic [15:0] model_data = 16'h0000;

  always #5 clk = ~clk;

`ifdef EMIB_WR_PROTECT_EN
  emib_host_if #(
    .RD_LAT      (3),
    .TIMEOUT_CYC (1024),
    .PROT_BASE   (`ADDR_SZ'h100)
  ) dut (
`else
  emib_host_if #(
    .RD_LAT      (3),
    .TIMEOUT_CYC (1024)
  ) dut (
`endif
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_ext_cs_n        (cs_n),
    .i_ext_we_n        (we_n),
    .i_ext_oe_n        (oe_n),
    .i_ext_addr        (ext_addr),
    .i_ext_wdata       (ext_wdata),
    .o_ext_rdata       (ext_rdata),
    .o_ext_rdata_oe    (ext_rdata_oe),
    .o_wr_en_out       (wr_en),
    .o_emib_wr_address (wr_address),
    .o_emib_wr_data    (wr_data),
    .o_rd_en_out       (rd_en),
    .o_emib_rd_address (rd_address),
    .i_emib_rd_data    (emib_rd_data),
    .o_busy            (busy),
`ifdef EMIB_WR_PROTECT_EN
    .o_wr_reject_cnt   (reject_cnt),
`endif
    .o_timeout         (timeout)
  );

  assign emib_rd_data = rd_pipe[2] ? model_data : 16'hDEAD;

  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[1:0], rd_en};
    if (wr_en) begin
      wr_pulses++;
      last_wr_addr <= wr_address;
    end
    if (rd_en) rd_pulses++;
    if (timeout) tmo_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a read request; n is cycles since the strobe fall (20 = never seen).
  task automatic wait_rd_en(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rd_en && n < 20);
  endtask

  // Complete host write with strobes held low for 8 clocks.
  task automatic host_write(input logic [`ADDR_SZ-1:0] a, input logic [15:0] d);
    ext_addr = a;
    ext_wdata = d;
    ticks(3);
    cs_n = 1'b0;
    we_n = 1'b0;
    ticks(8);
    cs_n = 1'b1;
    we_n = 1'b1;
    ticks(5);
  endtask

  int w0, r0, t0, n, k;

  initial begin
    // Reset state
    ticks(3);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_oe", ext_rdata_oe, 0);
    check("rst_rdata", ext_rdata, 0);
    check("rst_timeout", timeout, 0);
    check("rst_wr_addr", wr_address, 0);
    rst_n = 1'b1;
    ticks(5);

    // Host write 0x012 / 0xA5C3: pulse three clocks after the strobe fall
    ext_addr = `ADDR_SZ'h012;
    ext_wdata = 16'hA5C3;
    ticks(3);
    w0 = wr_pulses;
    cs_n = 1'b0;
    we_n = 1'b0;
    tick();
    check("wr_early1", wr_en, 0);
    tick();
    check("wr_early2", wr_en, 0);
    tick();
    check("wr_pulse", wr_en, 1);
    check("wr_addr", wr_address, 32'h012);
    check("wr_data", wr_data, 32'hA5C3);
    check("wr_busy", busy, 1);
    tick();
    check("wr_pulse_end", wr_en, 0);
    ticks(4);
    cs_n = 1'b1;
    we_n = 1'b1;
    ticks(6);
    check("wr_count", wr_pulses - w0, 1);
    check("wr_idle", busy, 0);

    // Host read 0x020, model returns 0x1234
    model_data = 16'h1234;
    ext_addr = `ADDR_SZ'h020;
    ticks(3);
    r0 = rd_pulses;
    cs_n = 1'b0;
    oe_n = 1'b0;
    wait_rd_en(n);
    check("rd_latency", n, 3);
    check("rd_addr", rd_address, 32'h020);
    ticks(3);
    check("rd_oe_before", ext_rdata_oe, 0);
    tick();
    check("rd_oe_on", ext_rdata_oe, 1);
    check("rd_data", ext_rdata, 32'h1234);
    ticks(3);
    check("rd_oe_hold", ext_rdata_oe, 1);
    oe_n = 1'b1;
    ticks(2);
    check("rd_oe_after_rise", ext_rdata_oe, 1);
    tick();
    check("rd_oe_off", ext_rdata_oe, 0);
    check("rd_data_kept", ext_rdata, 32'h1234);
    cs_n = 1'b1;
    ticks(4);
    check("rd_count", rd_pulses - r0, 1);

    // Write and read strobes together: write wins
    ext_addr = `ADDR_SZ'h005;
    ext_wdata = 16'h0BEE;
    ticks(3);
    w0 = wr_pulses;
    r0 = rd_pulses;
    cs_n = 1'b0;
    we_n = 1'b0;
    oe_n = 1'b0;
    ticks(8);
    cs_n = 1'b1;
    we_n = 1'b1;
    oe_n = 1'b1;
    ticks(5);
    check("both_wr_count", wr_pulses - w0, 1);
    check("both_rd_count", rd_pulses - r0, 0);
    check("both_wr_addr", last_wr_addr, 32'h005);
    check("both_wr_data", wr_data, 32'h0BEE);

    // Read held open: timeout 1024 cycles after the request cycle
    model_data = 16'h4321;
    ext_addr = `ADDR_SZ'h030;
    ticks(3);
    r0 = rd_pulses;
    t0 = tmo_pulses;
    cs_n = 1'b0;
    oe_n = 1'b0;
    wait_rd_en(n);
    check("tmo_rd_latency", n, 3);
    k = 0;
    while (!timeout && k < 1200) begin
      tick();
      k++;
    end
    check("tmo_cycle", k, 1024);
    check("tmo_oe_off", ext_rdata_oe, 0);
    check("tmo_idle", busy, 0);
    tick();
    check("tmo_pulse_end", timeout, 0);
    ticks(70);
    check("tmo_count", tmo_pulses - t0, 1);
    check("tmo_no_retry", rd_pulses - r0, 1);
    check("tmo_still_idle", busy, 0);
    cs_n = 1'b1;
    oe_n = 1'b1;
    ticks(4);

    // Reset during RD_WAIT with oe_n still low
    model_data = 16'h5A5A;
    ext_addr = `ADDR_SZ'h040;
    ticks(3);
    cs_n = 1'b0;
    oe_n = 1'b0;
    wait_rd_en(n);
    check("rstrd_latency", n, 3);
    tick();
    rst_n = 1'b0;
    #1;
    check("rstrd_busy", busy, 0);
    check("rstrd_rd_en", rd_en, 0);
    check("rstrd_oe", ext_rdata_oe, 0);
    check("rstrd_rdata", ext_rdata, 0);
    check("rstrd_rd_addr", rd_address, 0);
    ticks(2);
    rst_n = 1'b1;
    r0 = rd_pulses;
    ticks(10);
    check("rstrd_no_req", rd_pulses - r0, 0);
    check("rstrd_idle", busy, 0);
    cs_n = 1'b1;
    oe_n = 1'b1;
    ticks(4);
    cs_n = 1'b0;
    oe_n = 1'b0;
    wait_rd_en(n);
    check("rstrd_new_latency", n, 3);
    check("rstrd_new_addr", rd_address, 32'h040);
    ticks(4);
    check("rstrd_new_data", ext_rdata, 32'h5A5A);
    check("rstrd_new_oe", ext_rdata_oe, 1);
    cs_n = 1'b1;
    oe_n = 1'b1;
    ticks(5);

`ifdef EMIB_WR_PROTECT_EN
    // Write protection from 0x100 upward
    w0 = wr_pulses;
    host_write(`ADDR_SZ'h100, 16'h1111);
    check("prot_drop", wr_pulses - w0, 0);
    check("prot_cnt1", reject_cnt, 1);
    w0 = wr_pulses;
    host_write(`ADDR_SZ'h0FF, 16'h2222);
    check("prot_pass", wr_pulses - w0, 1);
    check("prot_pass_addr", last_wr_addr, 32'h0FF);
    check("prot_cnt_kept", reject_cnt, 1);
`else
    // Unprotected build forwards high addresses
    w0 = wr_pulses;
    host_write(`ADDR_SZ'h100, 16'h1111);
    check("hi_wr_pass", wr_pulses - w0, 1);
    check("hi_wr_addr", last_wr_addr, 32'h100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/emib_host_if.md
Name: emib_host_if

Overview:
- Upstream stage of the EMIB bus selector. Bridges the external asynchronous host bus (CS/WE/OE strobes, address, 16-bit data) into single-cycle EMIB RAM read and write requests in the i_clk domain.
- Returns read data to the host with a fixed-latency capture.
- Outputs drive the selector's EMIB write request (wr_en/address/data) and EMIB read request (rd_en/address); input i_emib_rd_data is the selector's EMIB read-data output.

Parameters:
RD_LAT, 3, cycles from o_rd_en_out assertion to the cycle i_emib_rd_data is valid
TIMEOUT_CYC, 1024, max cycles an access may stay open before forced abort (width 11 bits)
PROT_BASE, `ADDR_SZ'h0, lowest write-protected address (used only with EMIB_WR_PROTECT_EN)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_ext_cs_n  in  1  host chip select, async, active low
i_ext_we_n  in  1  host write strobe, async, active low
i_ext_oe_n  in  1  host read strobe, async, active low
i_ext_addr  in  `ADDR_SZ  host word address
i_ext_wdata  in  16  host write data
o_ext_rdata  out  16  read data to host pads
o_ext_rdata_oe  out  1  host data-bus drive enable
o_wr_en_out  out  1  EMIB write request, 1-cycle pulse
o_emib_wr_address  out  `ADDR_SZ  EMIB write address
o_emib_wr_data  out  16  EMIB write data
o_rd_en_out  out  1  EMIB read request, 1-cycle pulse
o_emib_rd_address  out  `ADDR_SZ  EMIB read address
i_emib_rd_data  in  16  EMIB read data from bus selector
o_busy  out  1  high whenever state != IDLE
o_timeout  out  1  1-cycle pulse on access abort

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is asynchronous, active-low (i_rst_n). All outputs reset to 0. Synchronizer flops reset to 1. State resets to IDLE.
- Synchronization: cs_n, we_n and oe_n each pass through 2 flops; only synced versions are used. Address and data are sampled unsynchronized. Host guarantees they are stable from 3 clocks before the strobe falls until the strobe rises.
- Arm flag:
  - Cleared at reset.
  - Set once synced cs_n=1 or (we_n=1 and oe_n=1).
  - An access starts only while armed. A strobe held low across reset release is ignored until released.
- FSM: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_HOLD, WAIT_END.
- IDLE:
  - armed & cs_n=0 & we_n=0 → latch addr/wdata, go WR_REQ. Write wins when we_n and oe_n are both low.
  - Else armed & cs_n=0 & oe_n=0 → latch addr, go RD_REQ.
  - Clear arm on access start.
- WR_REQ: o_wr_en_out=1 for exactly this cycle, with latched address/data → WAIT_END.
- RD_REQ: o_rd_en_out=1 for this cycle with latched address. Counter=1 → RD_WAIT.
- RD_WAIT:
  - Counter increments each cycle.
  - When counter==RD_LAT, capture i_emib_rd_data into o_ext_rdata, set o_ext_rdata_oe=1 → RD_HOLD.
  - Capture cycle is exactly RD_LAT cycles after the o_rd_en_out cycle.
- RD_HOLD: keep o_ext_rdata/oe until synced oe_n=1 or cs_n=1. Then oe=0 (o_ext_rdata holds its last value) → IDLE.
- WAIT_END: stay until synced cs_n=1 or we_n=1 → IDLE.
- Address/data outputs: hold last latched values outside request cycles. The selector consumes them only under enable.
- Timeout:
  - An 11-bit counter clears on access start and runs in every non-IDLE state.
  - At TIMEOUT_CYC: force IDLE, o_ext_rdata_oe=0, o_timeout pulse 1 cycle. Arm stays clear until release.
- Back-to-back accesses: a new access needs strobe release (arm) in between. Minimum host cycle = 2 sync + 1 + RD_LAT + release sync.
- Reset mid-operation: immediate IDLE, all request and oe outputs low. No partial request is re-issued.

Optional Feature:
EMIB_WR_PROTECT_EN
- Defined: a write with latched address >= PROT_BASE is dropped. WR_REQ goes straight to WAIT_END without pulsing o_wr_en_out. A 16-bit saturating counter o_wr_reject_cnt (extra output port, reset 0) increments once per dropped write.
- Undefined: all writes are forwarded; port o_wr_reject_cnt does not exist.

Test Plan:
- Host write addr=0x012, data=0xA5C3, we_n low 8 clks → exactly one o_wr_en_out pulse with 0x012/0xA5C3, 3 clks after the we_n fall, none after.
- Host read addr=0x020, model returns 0x1234 exactly 3 clks after o_rd_en_out → o_ext_rdata=0x1234, oe=1 until 2 clks after oe_n rise.
- we_n and oe_n low together at addr=0x005 → write pulse only, o_rd_en_out never asserted.
- Hold oe_n low 1100 clks (TIMEOUT_CYC=1024) → o_timeout single pulse at count 1024, oe drops, no new access until oe_n released.
- Assert reset during RD_WAIT with oe_n still low → outputs 0; after release, no request until oe_n high then low again.
- With EMIB_WR_PROTECT_EN, PROT_BASE=0x100: write 0x100 → no pulse, reject_cnt=1; write 0x0FF → pulse, reject_cnt stays 1.
